// File: rtl/core_inst_sequencer.sv
// core_inst_sequencer: drives the systolic core's 35-bit instruction word through one output tile
// (9 kernel passes, then 16 accumulation readouts). Define SEQ_PERF_CNT_EN to enable perf_cycles.
module core_inst_sequencer #(
    parameter int col      = 8,
    parameter int row      = 8,
    parameter int len_kij  = 9,
    parameter int len_nij  = 36,
    parameter int len_onij = 16,
    parameter int W_BASE   = 1024,
    parameter int RST_CYC  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    output logic        busy,
    output logic        done,
    output logic [34:0] inst,
    output logic        core_rst,
    output logic [3:0]  kij_idx,
    output logic [4:0]  onij_idx,
    output logic        out_valid,
    output logic [15:0] perf_cycles
);
    // Kernel is KW x KW, input image IW wide, output image OW wide.
    localparam int KW = 3, IW = 6, OW = 4;
    typedef enum logic [3:0] {IDLE, CRST, WL0, LOAD, ACTL0, EXEC, DRAIN, ARST, ARD, ATAIL, FIN} state_t;
    state_t      st_q, st_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [3:0]  kij_q, kij_d, o_q, o_d;
    logic [4:0]  onij_q, onij_d;
    logic        mode_q, mode_d, gap;
    logic [34:0] inst_q, inst_d;
    logic        busy_q, done_q, crst_q, ov_q;
    int          ki, ji, oi, nd;

    // Phase length in cycles; kernel-pass phases include their trailing idle gap cycle.
    function automatic logic [5:0] plen(state_t s, logic m);
        int n;
        n = m ? 2 * col : col;
        case (s)
            CRST:    return 6'(RST_CYC);
            WL0:     return 6'(n + 1);
            LOAD:    return 6'(n + row + 3);
            ACTL0:   return 6'(len_nij + 1);
            EXEC:    return 6'(len_nij + row + col + 1);
            DRAIN:   return 6'(len_nij + 1);
            ARD:     return 6'(len_kij);
            default: return 6'd1;
        endcase
    endfunction

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q + 6'd1;
        kij_d  = kij_q;
        o_d    = o_q;
        mode_d = mode_q;
        onij_d = onij_q;
        if (st_q == IDLE) begin
            cnt_d = '0;
            if (start) begin
                st_d   = CRST;
                kij_d  = '0;
                o_d    = '0;
                onij_d = '0;
                mode_d = mode;
            end
        end else if (cnt_q == plen(st_q, mode_q) - 6'd1) begin
            cnt_d = '0;
            st_d  = state_t'(st_q + 4'd1);
            if (st_q == DRAIN && kij_q != 4'(len_kij - 1)) begin
                st_d  = CRST;
                kij_d = kij_q + 4'd1;
            end
            if (st_q == ATAIL) begin
                st_d = (o_q == 4'(len_onij - 1)) ? FIN : ARST;
                o_d  = o_q + 4'd1;
            end
            if (st_q == FIN) st_d = IDLE;
        end
        // onij_idx only moves when reads of the next output begin, so it still names the finished output during out_valid
        if (st_d == ARD) onij_d = {1'b0, o_d};
    end

    always_comb begin
        ki     = int'(cnt_d);
        ji     = int'(kij_d);
        oi     = int'(o_d);
        nd     = mode_d ? 2 * col : col;
        gap    = (st_d inside {WL0, LOAD, ACTL0, EXEC, DRAIN}) && cnt_d == plen(st_d, mode_d) - 6'd1;
        inst_d = {mode_d, 1'b0, 2'b11, 11'd0, 2'b11, 18'd0};
        if (!gap)
            case (st_d)
                WL0: begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = 11'(W_BASE + ji * 2 * col + ki);
                    inst_d[2]    = 1'b1;
                end
                LOAD: begin
                    inst_d[0] = 1'b1;
                    inst_d[3] = ki < nd;
                end
                ACTL0: begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = 11'(ki);
                    inst_d[2]    = 1'b1;
                end
                EXEC: begin
                    inst_d[1] = 1'b1;
                    inst_d[3] = 1'b1;
                end
                DRAIN: begin
                    inst_d[6]     = 1'b1;
                    inst_d[32:31] = 2'b00;
                    inst_d[30:20] = 11'(ji * len_nij + ki);
                end
                ARD: begin
                    inst_d[33]    = ki != 0;
                    inst_d[32]    = 1'b0;
                    inst_d[30:20] = 11'(ki * len_nij + (oi / OW + ki / KW) * IW + oi % OW + ki % KW);
                end
                ATAIL:   inst_d[33] = 1'b1;
                default: ;
            endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            kij_q  <= '0;
            o_q    <= '0;
            onij_q <= '0;
            mode_q <= 1'b0;
            inst_q <= {1'b0, 1'b0, 2'b11, 11'd0, 2'b11, 18'd0};
            busy_q <= 1'b0;
            done_q <= 1'b0;
            crst_q <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            kij_q  <= kij_d;
            o_q    <= o_d;
            onij_q <= onij_d;
            mode_q <= mode_d;
            inst_q <= inst_d;
            busy_q <= !(st_d inside {IDLE, FIN});
            done_q <= st_d == FIN;
            crst_q <= st_d inside {CRST, ARST};
            ov_q   <= st_q == ATAIL;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] perf_q, perf_d;
    always_comb perf_d = (st_q == IDLE && start) ? 16'd0 :
                         (busy_q && perf_q != 16'hFFFF) ? perf_q + 16'd1 : perf_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) perf_q <= '0;
        else perf_q <= perf_d;
    end
    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

    assign inst      = inst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign core_rst  = crst_q;
    assign kij_idx   = kij_q;
    assign onij_idx  = onij_q;
    assign out_valid = ov_q;
endmodule

// File: tb/tb_core_inst_sequencer.sv
// tb_core_inst_sequencer: scoreboard bench; a tile-level trace model queues every expected busy/done
// cycle at start time and a negedge monitor pops and compares whenever the sequencer presents output.
module tb_core_inst_sequencer;
    localparam int COL = 8, ROW = 8, RST = 2;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, mode = 1'b0;
    logic        busy, done, core_rst, out_valid;
    logic [34:0] inst;
    logic [3:0]  kij_idx;
    logic [4:0]  onij_idx;
    logic [15:0] perf_cycles;

    typedef struct packed {
        logic [34:0] inst;
        logic        crst;
        logic        busy;
        logic        done;
        logic        ov;
        logic [3:0]  kij;
        logic [4:0]  onij;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0, checks = 0, run = 0, last_len = 0, n_done = 0;

    core_inst_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .busy(busy), .done(done),
        .inst(inst), .core_rst(core_rst), .kij_idx(kij_idx), .onij_idx(onij_idx),
        .out_valid(out_valid), .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [34:0] ins(bit m, bit acc, bit cenp, bit wenp, int ap, bit cenx, bit wenx, int ax,
                                        bit ofr, bit l0rd, bit l0wr, bit exe, bit ld);
        logic [10:0] a, x;
        a = 11'(ap);
        x = 11'(ax);
        return {m, acc, cenp, wenp, a, cenx, wenx, x, ofr, 2'b00, l0rd, l0wr, exe, ld};
    endfunction

    task automatic push(logic [34:0] i, bit crst, int kij, bit bsy, bit dn, bit ov, int onij);
        exp_t e;
        e.inst = i;
        e.crst = crst;
        e.busy = bsy;
        e.done = dn;
        e.ov   = ov;
        e.kij  = 4'(kij);
        e.onij = 5'(onij);
        exp_q.push_back(e);
    endtask

    // Whole-tile trace: one entry per cycle from the cycle after start through the done pulse.
    task automatic model_tile(bit m);
        int n;
        logic [34:0] idl;
        n   = m ? 2 * COL : COL;
        idl = ins(m, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int kj = 0; kj < 9; kj++) begin
            repeat (RST) push(idl, 1, kj, 1, 0, 0, 0);
            for (int c = 0; c < n; c++)
                push(ins(m, 0, 1, 1, 0, 0, 1, 1024 + kj * 2 * COL + c, 0, 0, 1, 0, 0), 0, kj, 1, 0, 0, 0);
            push(idl, 0, kj, 1, 0, 0, 0);
            for (int c = 0; c < n + ROW + 2; c++)
                push(ins(m, 0, 1, 1, 0, 1, 1, 0, 0, c < n, 0, 0, 1), 0, kj, 1, 0, 0, 0);
            push(idl, 0, kj, 1, 0, 0, 0);
            for (int t = 0; t < 36; t++)
                push(ins(m, 0, 1, 1, 0, 0, 1, t, 0, 0, 1, 0, 0), 0, kj, 1, 0, 0, 0);
            push(idl, 0, kj, 1, 0, 0, 0);
            for (int t = 0; t < 52; t++)
                push(ins(m, 0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 1, 0), 0, kj, 1, 0, 0, 0);
            push(idl, 0, kj, 1, 0, 0, 0);
            for (int t = 0; t < 36; t++)
                push(ins(m, 0, 0, 0, kj * 36 + t, 1, 1, 0, 1, 0, 0, 0, 0), 0, kj, 1, 0, 0, 0);
            push(idl, 0, kj, 1, 0, 0, 0);
        end
        for (int o = 0; o < 16; o++) begin
            push(idl, 1, 8, 1, 0, o > 0, o - 1);
            for (int k = 0; k < 9; k++)
                push(ins(m, k > 0, 0, 1, k * 36 + (o / 4 + k / 3) * 6 + o % 4 + k % 3, 1, 1, 0, 0, 0, 0, 0, 0),
                     0, 8, 1, 0, 0, 0);
            push(ins(m, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0), 0, 8, 1, 0, 0, 0);
        end
        push(idl, 0, 8, 0, 1, 1, 15);
    endtask

    task automatic chk(string nm, longint act, longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && (busy || done)) begin
                if (busy) run++;
                else begin
                    last_len = run;
                    n_done++;
                    run = 0;
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got busy=%0b done=%0b inst=%h with nothing queued", busy, done, inst);
                end else begin
                    e = exp_q.pop_front();
                    if (inst !== e.inst || core_rst !== e.crst || busy !== e.busy || done !== e.done ||
                        out_valid !== e.ov || kij_idx !== e.kij || (e.ov && onij_idx !== e.onij)) begin
                        errors++;
                        $display("FAIL cycle_%0d: got inst=%h rst=%0b busy=%0b done=%0b ov=%0b kij=%0d onij=%0d expected inst=%h rst=%0b busy=%0b done=%0b ov=%0b kij=%0d onij=%0d",
                                 exp_q.size(), inst, core_rst, busy, done, out_valid, kij_idx, onij_idx,
                                 e.inst, e.crst, e.busy, e.done, e.ov, e.kij, e.onij);
                    end
                end
            end else run = 0;
        end
    end

    // Called #1 after a clock edge; start is issued in the current cycle.
    task automatic run_tile(bit m, bit noisy);
        int nd;
        nd    = n_done;
        start = 1'b1;
        mode  = m;
        model_tile(m);
        @(posedge clk);
        #1;
        for (int j = 0; j < 2100 && exp_q.size() > 0; j++) begin
            start = noisy && (exp_q.size() == 1 || $urandom_range(0, 5) == 0);
            mode  = 1'($urandom);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk("tile_timeout_left", longint'(exp_q.size()), 0);
        exp_q.delete();
        chk("done_pulses", longint'(n_done - nd), 1);
        chk(m ? "tile_len_mode1" : "tile_len_mode0", longint'(last_len), m ? 1733 : 1589);
`ifdef SEQ_PERF_CNT_EN
        chk("perf_cycles", longint'(perf_cycles), m ? 1733 : 1589);
`else
        chk("perf_cycles_off", longint'(perf_cycles), 0);
`endif
    endtask

    task automatic chk_reset_state(string tag);
        chk({tag, "_inst"}, longint'(inst), longint'(ins(0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0)));
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_done"}, longint'(done), 0);
        chk({tag, "_core_rst"}, longint'(core_rst), 0);
        chk({tag, "_out_valid"}, longint'(out_valid), 0);
        chk({tag, "_kij"}, longint'(kij_idx), 0);
        chk({tag, "_onij"}, longint'(onij_idx), 0);
        chk({tag, "_perf"}, longint'(perf_cycles), 0);
    endtask

    initial begin
        int nd;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", longint'(busy), 0);
        run_tile(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        run_tile(1'b1, 1'b1);
        run_tile(1'($urandom), 1'b1);
        nd    = n_done;
        start = 1'b1;
        mode  = 1'b0;
        model_tile(1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int j = 0; j < 2000 && !(kij_idx == 4 && inst[1]); j++) begin
            @(posedge clk);
            #1;
        end
        chk("reach_exec_kij4", longint'(kij_idx == 4 && inst[1]), 1);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk_reset_state("midreset");
        @(posedge clk);
        #1;
        chk_reset_state("midreset_next");
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_partial_done", longint'(n_done - nd), 0);
        chk("post_reset_busy", longint'(busy), 0);
        run_tile(1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("final_idle_busy", longint'(busy), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
